// File: rtl/dm_pkg.sv
// Shared constants for the two-master data-memory arbiter.
// Holds the widths, port indices and common byte-enable patterns.
package dm_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Width of the port-1 starvation counter; covers STARVE_MAX up to 15.
    localparam int CNT_W  = 4;

    localparam int P_CPU  = 0;
    localparam int P_DMA  = 1;

    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;

    // A granted access only writes memory when at least one byte lane is enabled.
    function automatic logic is_mem_write(input logic we, input logic [BE_W-1:0] be);
        return we && (be != '0);
    endfunction

endpackage

// File: rtl/dm_arb_core.sv
// Grant logic for the data-memory arbiter.
// Port 0 has fixed priority; port 1 is force-granted after STARVE_MAX denied cycles.
import dm_pkg::*;

module dm_arb_core #(
    parameter int STARVE_MAX = 4
) (
    input  logic clock,
    input  logic rst_n,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_gnt,
    output logic m1_gnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             force_q;
    logic             force_next;

    // Grants are suppressed while reset is asserted so nothing reaches memory.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (force_q) begin
                if (m1_req) begin
                    m1_gnt = 1'b1;
                end else if (m0_req) begin
                    m0_gnt = 1'b1;
                end
            end else begin
                if (m0_req) begin
                    m0_gnt = 1'b1;
                end else if (m1_req) begin
                    m1_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_next   = starve_cnt;
        force_next = force_q;
        if (!m1_req || m1_gnt) begin
            cnt_next = '0;
        end else if (starve_cnt != CNT_MAX) begin
            cnt_next = starve_cnt + 1'b1;
        end
        // force stays armed until port 1 actually gets its access
        if (m1_gnt) begin
            force_next = 1'b0;
        end else if (cnt_next == CNT_MAX) begin
            force_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            force_q    <= 1'b0;
        end else begin
            starve_cnt <= cnt_next;
            force_q    <= force_next;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter and sequencer for the shared 4 KB data memory.
// One word access per clock; writes commit at the grant edge, reads return one cycle later.
import dm_pkg::*;

module dm_arbiter #(
    parameter int ADDR_W     = dm_pkg::ADDR_W,
    parameter int DATA_W     = dm_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] dm_addr,
    output logic [BE_W-1:0]   dm_be,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_dout
);

    logic m0_rd_issue;
    logic m1_rd_issue;
    logic m0_rd_pend;
    logic m1_rd_pend;

    dm_arb_core #(
        .STARVE_MAX (STARVE_MAX)
    ) u_core (
        .clock  (clock),
        .rst_n  (rst_n),
        .m0_req (m0_req),
        .m1_req (m1_req),
        .m0_gnt (m0_gnt),
        .m1_gnt (m1_gnt)
    );

    // Idle buses are driven to zero so the memory sees a quiet interface.
    always_comb begin
        dm_addr = '0;
        dm_be   = '0;
        dm_din  = '0;
        dm_we   = 1'b0;
        if (m0_gnt) begin
            dm_addr = m0_addr;
            dm_be   = m0_be;
            dm_din  = m0_wdata;
            dm_we   = is_mem_write(m0_we, m0_be);
        end else if (m1_gnt) begin
            dm_addr = m1_addr;
            dm_be   = m1_be;
            dm_din  = m1_wdata;
            dm_we   = is_mem_write(m1_we, m1_be);
        end
    end

    assign m0_rd_issue = m0_gnt && !m0_we;
    assign m1_rd_issue = m1_gnt && !m1_we;

    // Read data is captured at the grant edge and held until the next read on that port.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m0_rd_pend <= 1'b0;
            m1_rd_pend <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_rd_pend <= m0_rd_issue;
            m1_rd_pend <= m1_rd_issue;
            if (m0_rd_issue) begin
                m0_rdata <= dm_dout;
            end
            if (m1_rd_issue) begin
                m1_rdata <= dm_dout;
            end
        end
    end

    assign m0_rvalid = m0_rd_pend;
    assign m1_rvalid = m1_rd_pend;

endmodule
